// File: rtl/sprite_arbiter.sv
// sprite_arbiter: shares the single sprite_table ROM port among NREQ layer
// requesters. A combinational one-hot grant picks a winner each cycle, the
// winner's address is registered towards the ROM, and a tag pipeline of depth
// ROM_LAT+1 routes the returning texel to the requester that asked for it.
// Also counts the cycles per frame in which two or more requesters contended.
//
// Build option: define SPRITE_ARB_RR_EN for round-robin arbitration; when it
// is left undefined, arbitration is fixed priority and the lowest index wins.
module sprite_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 13,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               vs,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  output logic [NREQ-1:0]    GNT,
  output logic [AW-1:0]      SPRITE_ADDR,
  input  logic [DW-1:0]      SPRITE_DATA,
  output logic [NREQ-1:0]    RD_VALID,
  output logic [DW-1:0]      RD_DATA,
  output logic [15:0]        CONFLICT_CNT
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  // One slot of the return pipeline: which requester the ROM word belongs to.
  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [AW-1:0] win_addr;

  logic          lo_vld;
  logic [IW-1:0] lo_idx;

  logic [AW-1:0]   addr_q, addr_d;
  tag_t            tag_q [DEPTH];
  tag_t            tag_d [DEPTH];
  tag_t            tail;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            vs_q;
  logic            frame_edge;
  logic            conflict;
  logic [15:0]     acc_inc;
  logic [15:0]     conf_acc_q, conf_acc_d;
  logic [15:0]     conf_cnt_q, conf_cnt_d;

`ifdef SPRITE_ARB_RR_EN
  logic          hi_vld;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Winner selection and one-hot grant; purely combinational, so GNT tracks
  // REQ even while RESET is asserted.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    lo_vld   = 1'b0;
    lo_idx   = '0;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    GNT      = '0;
    // Lowest requesting index: the fixed-priority winner and the wrap-around
    // fallback of the round-robin search.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
      end
    end
`ifdef SPRITE_ARB_RR_EN
    // Lowest requesting index at or above the pointer wins; otherwise wrap.
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i] && (IW'(i) >= rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IW'(i);
      end
    end
    win_vld = lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
`else
    win_vld = lo_vld;
    win_idx = lo_idx;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (win_vld && (win_idx == IW'(i))) begin
        GNT[i]   = 1'b1;
        win_addr = REQ_ADDR[i*AW +: AW];
      end
    end
  end

  // Next state for the ROM address, tag pipeline, return path and counters.
  always_comb begin
    addr_d   = win_vld ? win_addr : addr_q;
    tag_d[0] = tag_t'{vld: win_vld, idx: win_idx};
    for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];

    // The tail slot lines up with the ROM word read for that grant.
    tail       = tag_q[DEPTH-1];
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (tail.vld) begin
      rd_data_d = SPRITE_DATA;
      for (int i = 0; i < NREQ; i++) begin
        if (tail.idx == IW'(i)) rd_valid_d[i] = 1'b1;
      end
    end

    // A conflict on the frame-edge cycle still belongs to the ending frame.
    frame_edge = vs & ~vs_q;
    conflict   = ($countones(REQ) >= 2);
    acc_inc    = conf_acc_q;
    if (conflict && (conf_acc_q != 16'hFFFF)) acc_inc = conf_acc_q + 16'd1;
    conf_cnt_d = frame_edge ? acc_inc : conf_cnt_q;
    conf_acc_d = frame_edge ? 16'd0 : acc_inc;

`ifdef SPRITE_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (win_vld) rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples its pre-edge inputs regardless of order.
    if (RESET) begin
      addr_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      vs_q       <= 1'b1;
      conf_acc_q <= '0;
      conf_cnt_q <= '0;
      // NOTE: only the valid bits of the tag pipeline are cleared; an index
      // is never looked at while its valid bit is low, so it needs no reset.
      for (int i = 0; i < DEPTH; i++) tag_q[i].vld <= 1'b0;
`ifdef SPRITE_ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      vs_q       <= vs;
      conf_acc_q <= conf_acc_d;
      conf_cnt_q <= conf_cnt_d;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
`ifdef SPRITE_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign SPRITE_ADDR  = addr_q;
  assign RD_VALID     = rd_valid_q;
  assign RD_DATA      = rd_data_q;
  assign CONFLICT_CNT = conf_cnt_q;

endmodule
